// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle arithmetic/logic ops, bit-serial
// shifts (one bit per cycle) and a shift-add multiplier (WIDTH cycles).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request to begin an operation
//   operation  4-bit opcode (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 SAR,
//              8 MUL,9 CMP, 10-15 undefined -> result 0, flags 1000)
//   operand1   first operand
//   operand2   second operand; shift count is operand2[SW-1:0]
//   busy       high while a shift or multiply is in progress
//   done       one-cycle pulse in the cycle after result/flags update
//   result     registered result, held between done pulses
//   flags      registered {Z,N,C,V}
//   dbg_state  current FSM state (IDLE=0, SHIFT=1, MUL=2)
//
// Handshake: start is accepted on a rising edge where start=1 and busy=0;
// operation/operands are sampled on that same edge. A start seen while busy=1
// is dropped without effect. busy is low in the cycle done is high, so a new
// start may be accepted then.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SAR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam logic [SW-1:0] cnt_one  = SW'(1);
  localparam logic [SW-1:0] mul_last = SW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;

  state_t state_q, state_d;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [SW-1:0]      cnt;

  logic               accept;
  logic               is_shift_in;
  logic [SW-1:0]      shift_cnt;

  assign shift_cnt   = operand2[SW-1:0];
  assign is_shift_in = (operation == OP_SHL) || (operation == OP_SHR) ||
                       (operation == OP_SAR);
  assign accept      = start && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  // Single-cycle datapath, evaluated on the incoming operands.
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  always_comb begin
    sum   = {1'b0, operand1} + {1'b0, operand2};
    diff  = {1'b0, operand1} - {1'b0, operand2};
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (operation)
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                (sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // diff[WIDTH] is the borrow: set when operand1 < operand2 unsigned.
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                (diff[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_AND: alu_r = operand1 & operand2;
      OP_OR:  alu_r = operand1 | operand2;
      OP_XOR: alu_r = operand1 ^ operand2;
      // Only the count-0 case finishes here: result passes operand1, C=0.
      OP_SHL, OP_SHR, OP_SAR: alu_r = operand1;
      default: alu_r = '0;  // undefined opcodes: Z=1 falls out of result=0
    endcase
    alu_flags = {(alu_r == '0), alu_r[WIDTH-1], alu_c, alu_v};
  end

  // One shift step on the working register; sh_out is the bit leaving it.
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  always_comb begin
    sh_next = {1'b0, work[WIDTH-1:1]};
    sh_out  = work[0];
    case (op_q)
      OP_SHL: begin
        sh_next = {work[WIDTH-2:0], 1'b0};
        sh_out  = work[WIDTH-1];
      end
      OP_SAR: sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
      default: ;
    endcase
  end

  // Shift-add multiply step. acc holds {partial product, remaining
  // multiplier bits}; each step conditionally adds the multiplicand to the
  // upper half and shifts the whole accumulator right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift_in && (shift_cnt != '0)) state_d = SHIFT;
          else if (operation == OP_MUL)          state_d = MUL;
        end
      end
      SHIFT, MUL: if (cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers. cnt counts remaining steps minus one, so the final
  // step is the one taken with cnt == 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      work   <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q <= operation;
            if (operation == OP_MUL) begin
              mcand <= operand1;
              acc   <= {{WIDTH{1'b0}}, operand2};
              cnt   <= mul_last;
            end else if (is_shift_in && (shift_cnt != '0)) begin
              work <= operand1;
              cnt  <= shift_cnt - cnt_one;
            end else begin
              // CMP only updates flags; result keeps its previous value.
              if (operation != OP_CMP) result <= alu_r;
              flags <= alu_flags;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= sh_next;
          cnt  <= cnt - cnt_one;
          if (cnt == '0) begin
            result <= sh_next;
            flags  <= {(sh_next == '0), sh_next[WIDTH-1], sh_out, 1'b0};
            done   <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt - cnt_one;
          if (cnt == '0) begin
            result <= acc_next[WIDTH-1:0];
            flags  <= {(acc_next[WIDTH-1:0] == '0), acc_next[WIDTH-1],
                       (acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
